// File: rtl/fp_mul_pkg.sv
// Shared types, flag bit positions and canonical special-value builders for fp_mul_pipe.
// Builders return a 64-bit word; callers keep the low 1+exp_w+man_w bits.
package fp_mul_pkg;

  typedef enum logic [1:0] {
    FP_ZERO = 2'd0,
    FP_NORM = 2'd1,
    FP_INF  = 2'd2,
    FP_NAN  = 2'd3
  } fp_class_e;

  localparam int FLAG_W   = 3;
  localparam int FLAG_INV = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_UDF = 0;

  // Canonical NaN: sign 0, exponent and mantissa all ones.
  function automatic logic [63:0] fp_nan(input int exp_w, input int man_w);
    return (64'd1 << (exp_w + man_w)) - 64'd1;
  endfunction

  // Infinity keeps the explicit integer bit set: exponent all ones, mantissa 10..0.
  function automatic logic [63:0] fp_inf(input logic s, input int exp_w, input int man_w);
    return ({63'd0, s} << (exp_w + man_w))
         | (((64'd1 << exp_w) - 64'd1) << man_w)
         | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic [63:0] fp_zero(input logic s, input int exp_w, input int man_w);
    return {63'd0, s} << (exp_w + man_w);
  endfunction

endpackage

// File: rtl/fp_mul_norm_round.sv
// Third-stage combinational datapath: normalise, round, range check and pack.
// FP_MUL_RNE_EN selects round-to-nearest-even; otherwise the kept field is truncated.
module fp_mul_norm_round
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 6
) (
  input  logic                      i_sign,
  input  fp_class_e                 i_cls,
  input  logic [2*MAN_W-1:0]        i_prod,
  input  logic signed [EXP_W+1:0]   i_exp,
  output logic [EXP_W+MAN_W:0]      o_result,
  output logic [FLAG_W-1:0]         o_flags
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam logic [63:0] NAN64  = fp_nan(EXP_W, MAN_W);
  localparam logic [63:0] INF64  = fp_inf(1'b0, EXP_W, MAN_W);
  localparam logic [63:0] ZERO64 = fp_zero(1'b0, EXP_W, MAN_W);
  localparam logic [W-1:0] NAN_P  = NAN64[W-1:0];
  localparam logic [W-1:0] INF_P  = INF64[W-1:0];
  localparam logic [W-1:0] ZERO_P = ZERO64[W-1:0];
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);
  localparam logic signed [EW-1:0] NIL_E  = '0;
  localparam logic signed [EW-1:0] EMAX_E = EW'((1 << EXP_W) - 1);

  logic                    w_top;
  logic [MAN_W-1:0]        w_kept;
  logic signed [EW-1:0]    w_exp_n;
  logic [MAN_W-1:0]        w_man;
  logic signed [EW-1:0]    w_exp_r;

  always_comb begin
    w_top = i_prod[2*MAN_W-1];
    if (w_top) begin
      w_kept  = i_prod[2*MAN_W-1 -: MAN_W];
      w_exp_n = i_exp + ONE_E;
    end else begin
      w_kept  = i_prod[2*MAN_W-2 -: MAN_W];
      w_exp_n = i_exp;
    end
  end

`ifdef FP_MUL_RNE_EN
  logic             w_guard;
  logic             w_sticky;
  logic [MAN_W:0]   w_sum;

  always_comb begin
    w_guard  = w_top ? i_prod[MAN_W-1]    : i_prod[MAN_W-2];
    w_sticky = w_top ? |i_prod[MAN_W-2:0] : |i_prod[MAN_W-3:0];
    w_sum    = {1'b0, w_kept} + {{MAN_W{1'b0}}, w_guard & (w_sticky | w_kept[0])};
    // Carry out of the increment leaves 10..0 in the upper bits.
    if (w_sum[MAN_W]) begin
      w_man   = w_sum[MAN_W:1];
      w_exp_r = w_exp_n + ONE_E;
    end else begin
      w_man   = w_sum[MAN_W-1:0];
      w_exp_r = w_exp_n;
    end
  end
`else
  logic w_unused_lsbs;
  assign w_unused_lsbs = |i_prod[MAN_W-2:0];
  assign w_man   = w_kept;
  assign w_exp_r = w_exp_n;
`endif

  always_comb begin
    o_flags  = '0;
    o_result = {i_sign, w_exp_r[EXP_W-1:0], w_man};
    unique case (i_cls)
      FP_NAN: begin
        o_result          = NAN_P;
        o_flags[FLAG_INV] = 1'b1;
      end
      FP_INF:  o_result = {i_sign, INF_P[W-2:0]};
      FP_ZERO: o_result = {i_sign, ZERO_P[W-2:0]};
      default: begin
        if (w_exp_r >= EMAX_E) begin
          o_result          = {i_sign, INF_P[W-2:0]};
          o_flags[FLAG_OVF] = 1'b1;
        end else if (w_exp_r <= NIL_E) begin
          o_result          = {i_sign, ZERO_P[W-2:0]};
          o_flags[FLAG_UDF] = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier with valid/ready backpressure and status flags.
// Rounding mode is chosen at build time by FP_MUL_RNE_EN (see fp_mul_norm_round).
module fp_mul_pipe
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 6,
  parameter int BIAS  = 2**(EXP_W-1)-1,
  parameter int W     = 1+EXP_W+MAN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  input  logic              valid_in,
  output logic              ready_in,
  output logic [W-1:0]      result,
  output logic [FLAG_W-1:0] flags,
  output logic              valid_out,
  input  logic              ready_out
);
  localparam int STAGES = 3;
  localparam int EW     = EXP_W + 2;
  localparam int PW     = 2 * MAN_W;
  localparam logic [MAN_W-1:0]     MSB_ONE = {1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EW-1:0] BIAS_S  = EW'(BIAS);

  // Infinity is recognised by a zero fraction; the explicit integer bit is ignored.
  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-2:0] frac);
    if (e == '0) return FP_ZERO;
    if (e == '1) return (frac == '0) ? FP_INF : FP_NAN;
    return FP_NORM;
  endfunction

  logic [STAGES:1] r_vld_pipe;
  logic            w_adv;
  logic            w_xfer;

  assign w_adv     = !r_vld_pipe[STAGES] || ready_out;
  assign ready_in  = w_adv && !rst;
  assign w_xfer    = valid_in && ready_in;
  assign valid_out = r_vld_pipe[STAGES];

  logic             r_s1_sign;
  fp_class_e        r_s1_cls_a, r_s1_cls_b;
  logic [EXP_W-1:0] r_s1_ea, r_s1_eb;
  logic [MAN_W-1:0] r_s1_ma, r_s1_mb;

  logic                 r_s2_sign;
  fp_class_e            r_s2_cls, w_s2_cls;
  logic [PW-1:0]        r_s2_prod, w_s2_prod;
  logic signed [EW-1:0] r_s2_exp, w_s2_exp;

  logic [W-1:0]      r_result, w_s3_result;
  logic [FLAG_W-1:0] r_flags, w_s3_flags;

  assign w_s2_prod = PW'(r_s1_ma) * PW'(r_s1_mb);
  assign w_s2_exp  = $signed({2'b00, r_s1_ea}) + $signed({2'b00, r_s1_eb}) - BIAS_S;

  always_comb begin
    w_s2_cls = FP_NORM;
    if (r_s1_cls_a == FP_NAN || r_s1_cls_b == FP_NAN ||
        (r_s1_cls_a == FP_ZERO && r_s1_cls_b == FP_INF) ||
        (r_s1_cls_a == FP_INF  && r_s1_cls_b == FP_ZERO))
      w_s2_cls = FP_NAN;
    else if (r_s1_cls_a == FP_INF || r_s1_cls_b == FP_INF)
      w_s2_cls = FP_INF;
    else if (r_s1_cls_a == FP_ZERO || r_s1_cls_b == FP_ZERO)
      w_s2_cls = FP_ZERO;
  end

  // Datapath registers carry no reset; the valid pipe qualifies them.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_s1_sign  <= a[W-1] ^ b[W-1];
      r_s1_cls_a <= classify(a[W-2 -: EXP_W], a[MAN_W-2:0]);
      r_s1_cls_b <= classify(b[W-2 -: EXP_W], b[MAN_W-2:0]);
      r_s1_ea    <= a[W-2 -: EXP_W];
      r_s1_eb    <= b[W-2 -: EXP_W];
      r_s1_ma    <= a[MAN_W-1:0] | MSB_ONE;
      r_s1_mb    <= b[MAN_W-1:0] | MSB_ONE;
      r_s2_sign  <= r_s1_sign;
      r_s2_cls   <= w_s2_cls;
      r_s2_prod  <= w_s2_prod;
      r_s2_exp   <= w_s2_exp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_result   <= '0;
      r_flags    <= '0;
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_xfer};
      if (r_vld_pipe[STAGES-1]) begin
        r_result <= w_s3_result;
        r_flags  <= w_s3_flags;
      end
    end
  end

  fp_mul_norm_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_norm_round (
    .i_sign   (r_s2_sign),
    .i_cls    (r_s2_cls),
    .i_prod   (r_s2_prod),
    .i_exp    (r_s2_exp),
    .o_result (w_s3_result),
    .o_flags  (w_s3_flags)
  );

  assign result = r_result;
  assign flags  = r_flags;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe: real-valued reference model plus scoreboard monitor.
module tb_fp_mul_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] a = '0, b = '0;
  logic        valid_in = 1'b0, ready_out = 1'b1;
  logic        ready_in, valid_out;
  logic [11:0] result;
  logic [2:0]  flags;

  always #5 clk = ~clk;

  fp_mul_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .result    (result),
    .flags     (flags),
    .valid_out (valid_out),
    .ready_out (ready_out)
  );

  int n_chk = 0, n_fail = 0, popped = 0;
  logic [14:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [11:0] res_prev = '0;
  logic [2:0]  flg_prev = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  // Reference: {flags, result} computed from real-valued operands.
  function automatic logic [14:0] model(input logic [11:0] x, input logic [11:0] y);
    int ex, ey, mx, my, e, m;
    bit zx, zy, ix, iy, nx, ny, s;
    real p, sc;
    ex = int'(x[10:6]); ey = int'(y[10:6]);
    mx = int'(x[5:0]);  my = int'(y[5:0]);
    zx = (ex == 0); zy = (ey == 0);
    ix = (ex == 31) && (mx % 32 == 0); iy = (ey == 31) && (my % 32 == 0);
    nx = (ex == 31) && (mx % 32 != 0); ny = (ey == 31) && (my % 32 != 0);
    s  = x[11] ^ y[11];
    if (nx || ny || (zx && iy) || (ix && zy)) return {3'b100, 12'h7FF};
    if (ix || iy) return {3'b000, s, 5'h1F, 6'h20};
    if (zx || zy) return {3'b000, s, 11'h000};
    p = (real'(mx | 32) / 32.0) * (real'(my | 32) / 32.0);
    e = ex + ey - 15;
    while (p >= 2.0) begin p = p / 2.0; e++; end
    sc = p * 32.0;
    m  = $rtoi(sc);
`ifdef FP_MUL_RNE_EN
    if ((sc - m) > 0.5 || ((sc - m) == 0.5 && (m % 2) == 1)) m++;
`endif
    if (m == 64) begin m = 32; e++; end
    if (e >= 31) return {3'b010, s, 5'h1F, 6'h20};
    if (e <= 0)  return {3'b001, s, 11'h000};
    return {3'b000, s, e[4:0], m[5:0]};
  endfunction

  always @(negedge clk) begin : mon
    logic [14:0] ex;
    if (rst) begin
      chk("ready_in_in_reset", ready_in, 0);
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", valid_out, 1);
        chk("hold_result", result, res_prev);
        chk("hold_flags", flags, flg_prev);
      end
      chk("ready_in_rule", ready_in, !valid_out || ready_out);
      if (exp_q.size() == 0) chk("no_spurious_valid", valid_out, 0);
      if (valid_out && ready_out && exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        chk("sb_result", result, ex[11:0]);
        chk("sb_flags", flags, ex[14:12]);
        popped++;
      end
      if (valid_in && ready_in) exp_q.push_back(model(a, b));
      stall_prev = valid_out && !ready_out;
      res_prev   = result;
      flg_prev   = flags;
    end
  end

  task automatic send(input logic [11:0] x, input logic [11:0] y);
    bit ok = 1'b0;
    @(posedge clk); #1;
    a = x; b = y; valid_in = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk); ok = ready_in;
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    chk("send_accepted", ok, 1);
  endtask

  task automatic single(input logic [11:0] x, input logic [11:0] y,
                        input logic [14:0] want, input string nm);
    int lat = 0;
    chk({nm, "_model"}, model(x, y), want);
    ready_out = 1'b1;
    send(x, y);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (valid_out) begin lat = k; break; end
    end
    chk({nm, "_latency"}, lat, 3);
    chk({nm, "_result"}, result, want[11:0]);
    chk({nm, "_flags"}, flags, want[14:12]);
  endtask

  logic [11:0] sa[8] = '{12'h3E0, 12'h3F0, 12'hBE0, 12'h3EF, 12'h7A0, 12'h060, 12'h000, 12'h7FF};
  logic [11:0] sb[8] = '{12'h420, 12'h3F0, 12'h420, 12'h3EF, 12'h420, 12'h060, 12'h7E0, 12'h3E0};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int p0, idx, c;
    bit blocked;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_valid_out", valid_out, 0);
    chk("reset_result", result, 0);
    chk("reset_flags", flags, 0);
    chk("reset_ready_in", ready_in, 1);

    single(12'h3E0, 12'h420, {3'b000, 12'h420}, "one_x_two");
    single(12'h3F0, 12'h3F0, {3'b000, 12'h424}, "onep5_sq");
    single(12'hBE0, 12'h420, {3'b000, 12'hC20}, "neg_two");
`ifdef FP_MUL_RNE_EN
    single(12'h3EF, 12'h3EF, {3'b000, 12'h423}, "round");
`else
    single(12'h3EF, 12'h3EF, {3'b000, 12'h422}, "round");
`endif
    single(12'h7A0, 12'h420, {3'b010, 12'h7E0}, "overflow");
    single(12'h060, 12'h060, {3'b001, 12'h000}, "underflow");
    single(12'h000, 12'h7E0, {3'b100, 12'h7FF}, "zero_x_inf");
    single(12'h7FF, 12'h3E0, {3'b100, 12'h7FF}, "nan_in");
    single(12'hFE0, 12'h3F0, {3'b000, 12'hFE0}, "neg_inf");

    // Stream with a downstream stall in cycles 4..7.
    @(posedge clk); #1;
    p0 = popped; idx = 0; c = 0; blocked = 1'b0;
    while ((idx < 8 || popped - p0 < 8) && c < 60) begin
      ready_out = !(c >= 4 && c <= 7);
      if (idx < 8) begin valid_in = 1'b1; a = sa[idx]; b = sb[idx]; end
      else valid_in = 1'b0;
      @(negedge clk);
      if (valid_in && !ready_in) blocked = 1'b1;
      if (valid_in && ready_in) idx++;
      @(posedge clk); #1;
      c++;
    end
    valid_in = 1'b0; ready_out = 1'b1;
    chk("stream_backpressure", blocked, 1);
    chk("stream_count", popped - p0, 8);
    chk("stream_drained", exp_q.size(), 0);

    // Reset with three results in flight.
    ready_out = 1'b0;
    p0 = popped;
    for (int k = 0; k < 3; k++) begin
      a = sa[k]; b = sb[k]; valid_in = 1'b1;
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    chk("inflight_valid", valid_out, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("flush_valid_out", valid_out, 0);
    chk("flush_ready_in", ready_in, 1);
    ready_out = 1'b1;
    repeat (6) @(negedge clk);
    chk("flush_none_emerged", popped, p0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, fully pipelined floating-point multiplier.
- Successor to the fixed 12-bit single-cycle debug multiplier: adds configurable exponent and mantissa widths, valid/ready backpressure, special-value handling, rounding and status flags.
- Sits between operand staging and the result FIFO in the arithmetic datapath.
- Default geometry keeps the existing 12-bit format: sign, 5-bit exponent with bias 15, 6-bit mantissa with an explicit leading one.

Parameters:
- EXP_W, 5, exponent field width.
- MAN_W, 6, mantissa field width; MSB is the explicit integer bit.
- BIAS, 2**(EXP_W-1)-1, exponent bias.
- W, 1+EXP_W+MAN_W, total word width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- a  in  W  operand A.
- b  in  W  operand B.
- valid_in  in  1  operands valid.
- ready_in  out  1  block accepts operands this cycle.
- result  out  W  product.
- flags  out  3  {invalid, overflow, underflow}, aligned with result.
- valid_out  out  1  result valid.
- ready_out  in  1  downstream accepts result.

Behaviour:
- Reset: one clock, synchronous and active-high.
  - All stage valids clear; result=0, flags=0, valid_out=0.
  - ready_in=0 while rst is high.
  - Reset asserted mid-operation discards all in-flight data in that cycle.
- Pipeline: 3 stages, latency 3 cycles with no stall.
  - S1: unpack, classify, sign = a.s XOR b.s.
  - S2: MAN_W x MAN_W mantissa product; exponent sum ea+eb-BIAS in EXP_W+2 signed bits.
  - S3: normalise, round, range check, pack.
- Handshake:
  - adv = !s3_valid | ready_out; ready_in = adv & !rst.
  - All stages advance together when adv=1, which absorbs bubbles.
  - A transfer occurs when valid_in & ready_in.
  - While valid_out & !ready_out, result, flags and valid_out hold stable and no stage moves.
  - Throughput is 1 per cycle with ready_out held high.
- Operand classes:
  - exp==0 -> zero (mantissa ignored).
  - exp==all-ones with mantissa==0 -> inf.
  - exp==all-ones with mantissa!=0 -> NaN.
  - Otherwise normal; the mantissa MSB is forced to 1 on unpack.
- Special results:
  - NaN operand, or zero x inf -> canonical NaN 0_11..1_11..1, invalid=1.
  - inf x (normal or inf) -> signed inf, no flag.
  - zero x (normal or zero) -> signed zero, no flag.
- Normalise:
  - Product is 2*MAN_W bits.
  - If the top bit is set, take the upper MAN_W bits and exp+1.
  - Otherwise take the bits one lower.
  - Guard = next bit below the kept field; sticky = OR of all remaining lower bits.
- Rounding: see Optional Feature. A rounding carry-out renormalises to 10..0 with exp+1.
- Range (applied after rounding):
  - exp >= 2**EXP_W-1 -> signed inf, overflow=1.
  - exp <= 0 -> signed zero (flush), underflow=1.
  - Flags are mutually exclusive.

Optional Feature:
- Macro: FP_MUL_RNE_EN.
- Defined: round-to-nearest-even.
  - Increment when guard & (sticky | lsb).
- Undefined: truncation.
  - Guard and sticky are ignored; S3 has no incrementer.
- Latency and interface are identical in both builds.

Decomposition:
- Package fp_mul_pkg holds:
  - fp class enum (ZERO, NORM, INF, NAN);
  - flag bit index constants;
  - canonical NaN/inf/zero builder functions parameterised on EXP_W/MAN_W.
- One natural sub-module: fp_mul_norm_round, covering S3 combinational normalise, round, range check and pack.
- Stage registers and the handshake stay in the top level.

Test Plan:
- 0x3E0 (1.0) x 0x420 (2.0), ready_out=1 -> 0x420, flags=0, valid_out high exactly 3 cycles after acceptance.
- 0x3F0 x 0x3F0 (1.5 x 1.5) -> 0x424 (2.25); then 0xBE0 x 0x420 -> 0xC20 (-2.0).
- 0x3EF x 0x3EF -> 0x423 with FP_MUL_RNE_EN defined, 0x422 without; flags=0.
- Overflow, underflow and invalid cases:
  - 0x7A0 x 0x420 -> 0x7E0, flags=3'b010.
  - 0x060 x 0x060 -> 0x000, flags=3'b001.
  - 0x000 x 0x7E0 -> 0x7FF, flags=3'b100.
- Stream 8 operand pairs with ready_out low for cycles 4-7:
  - ready_in drops once S3 is full;
  - result holds stable while stalled;
  - all 8 results arrive in order, with none lost or duplicated.
- Assert rst for 1 cycle with 3 results in flight -> valid_out=0 the next cycle, none of the 3 ever emerge, and ready_in returns to 1.
